// File: rtl/serial_add_sub.sv
// Bit-serial LSB-first add/sub; done pulses the cycle after edge k+WIDTH for a start accepted at edge k.
// No backpressure: start is ignored while busy, and result/cout/ovf hold until the next completion.
module serial_add_sub #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   sa, sb, part;
  logic [CNT_W-1:0]   cnt;
  logic               opr, c, amsb, bmsb;
  logic               ai, bi, s, c_nxt, last, load;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ai        = sa[0];
    bi        = sb[0];
    s         = ai ^ bi ^ c;
    // Carry for add, borrow for subtract.
    c_nxt     = opr ? ((~ai & bi) | (c & ~(ai ^ bi)))
                    : ((ai & bi) | (c & (ai ^ bi)));
    last      = (cnt == CNT_W'(WIDTH-1));
    load      = 1'b0;
    case (state)
      IDLE: if (start) begin
        state_nxt = RUN;
        load      = 1'b1;
      end
      RUN:  if (last) state_nxt = DONE;
      DONE: begin
        if (start) begin
          state_nxt = RUN;
          load      = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      sa     <= '0;
      sb     <= '0;
      part   <= '0;
      cnt    <= '0;
      opr    <= 1'b0;
      c      <= 1'b0;
      amsb   <= 1'b0;
      bmsb   <= 1'b0;
      result <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
    end else if (load) begin
      sa   <= a;
      sb   <= b;
      opr  <= op;
      amsb <= a[WIDTH-1];
      bmsb <= b[WIDTH-1];
      c    <= 1'b0;
      cnt  <= '0;
      part <= '0;
    end else if (state == RUN) begin
      sa   <= {1'b0, sa[WIDTH-1:1]};
      sb   <= {1'b0, sb[WIDTH-1:1]};
      part <= {s, part[WIDTH-1:1]};
      c    <= c_nxt;
      cnt  <= cnt + CNT_W'(1);
      // Final bit: the just-computed bit is the result MSB.
      if (last) begin
        result <= {s, part[WIDTH-1:1]};
        cout   <= c_nxt;
        ovf    <= opr ? ((amsb != bmsb) && (s != amsb))
                      : ((amsb == bmsb) && (s != amsb));
      end
    end
  end

endmodule

// File: tb/tb_serial_add_sub.sv
// Directed self-checking bench for serial_add_sub (WIDTH=8).
module tb_serial_add_sub;
  logic       clk = 1'b0;
  logic       rst, start, op;
  logic [7:0] a, b;
  logic       busy, done, cout, ovf;
  logic [7:0] result;

  int checks = 0;
  int errors = 0;

  serial_add_sub #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts one operation from IDLE/DONE and checks latency and outputs.
  task automatic run_op(input string tag, input logic o, input logic [7:0] ia, input logic [7:0] ib,
                        input logic [7:0] er, input logic ec, input logic eo);
    int lat;
    lat = 0;
    start = 1'b1; op = o; a = ia; b = ib;
    tick();
    start = 1'b0;
    chk({tag, "_busy"}, busy, 1);
    for (int i = 1; i <= 20 && lat == 0; i++) begin
      tick();
      if (done) lat = i;
    end
    chk({tag, "_lat"}, lat, 8);
    chk({tag, "_res"}, result, er);
    chk({tag, "_cout"}, cout, ec);
    chk({tag, "_ovf"}, ovf, eo);
    tick();
    chk({tag, "_done_drop"}, done, 0);
  endtask

  initial begin
    int ndone, first, consec;
    logic [7:0] cap;
    logic [17:0] dv;

    rst = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
    tick(); tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_res", result, 0);
    chk("rst_cout", cout, 0);
    chk("rst_ovf", ovf, 0);
    rst = 1'b0;
    tick();

    run_op("sub1", 1'b1, 8'h5A, 8'h3C, 8'h1E, 1'b0, 1'b0);
    run_op("sub2", 1'b1, 8'h3C, 8'h5A, 8'hE2, 1'b1, 1'b0);
    run_op("sub3", 1'b1, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
    run_op("add1", 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0);
    run_op("add2", 1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1);

    // Start pulse mid-run must be ignored.
    start = 1'b1; op = 1'b0; a = 8'h10; b = 8'h20;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    start = 1'b1; a = 8'hAA; op = 1'b1;
    tick();
    start = 1'b0;
    ndone = 0; first = 0; cap = '0;
    for (int i = 5; i <= 20; i++) begin
      tick();
      if (done) begin
        ndone++;
        if (first == 0) begin first = i; cap = result; end
      end
    end
    chk("ign_ndone", ndone, 1);
    chk("ign_lat", first, 8);
    chk("ign_res", cap, 8'h30);

    // Back-to-back: start held high through DONE.
    start = 1'b1; op = 1'b0; a = 8'h01; b = 8'h02;
    tick();
    a = 8'h05; b = 8'h03; op = 1'b1;
    dv = '0; cap = '0;
    for (int i = 1; i <= 17; i++) begin
      tick();
      dv[i] = done;
      if (i == 8) cap = result;
      if (i == 9) begin
        chk("b2b_busy9", busy, 1);
        start = 1'b0;
      end
    end
    consec = 0;
    for (int i = 1; i < 17; i++) if (dv[i] && dv[i+1]) consec++;
    chk("b2b_first_res", cap, 8'h03);
    chk("b2b_dv8", dv[8], 1);
    chk("b2b_dv17", dv[17], 1);
    chk("b2b_count", $countones(dv), 2);
    chk("b2b_consec", consec, 0);
    chk("b2b_res", result, 8'h02);
    chk("b2b_cout", cout, 0);
    tick();

    // Reset at edge k+4 aborts.
    start = 1'b1; op = 1'b0; a = 8'h10; b = 8'h20;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_res", result, 0);
    chk("abort_cout", cout, 0);
    chk("abort_ovf", ovf, 0);
    rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done) ndone++;
    end
    chk("abort_nodone", ndone, 0);
    run_op("post", 1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
